// File: rtl/control_unit_if.sv
// Bus between the sequencer/testbench and the control unit.
// Carries run request, instruction fields, ALU flags and all status.
interface control_unit_if;
  logic        start;
  logic [19:0] InstrControl;
  logic [3:0]  ALUFlags;
  logic [12:0] Control;
  logic        dp_rst;
  logic        done;
  logic        illegal;
  logic [3:0]  flags;
  logic [15:0] instr_count;

  modport master (
    output start, InstrControl, ALUFlags,
    input  Control, dp_rst, done, illegal,
    input  flags, instr_count
  );

  modport slave (
    input  start, InstrControl, ALUFlags,
    output Control, dp_rst, done, illegal,
    output flags, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// Single-cycle ARM-subset control unit with IDLE/RUN/HALTED sequencing,
// conditional execution, flag register and retired-instruction counter.
module control_unit (
  input  logic            clk,
  input  logic            rst,
  control_unit_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;
  localparam logic [3:0] A_AND = 4'b0010;
  localparam logic [3:0] A_ORR = 4'b0011;
  localparam logic [3:0] A_EOR = 4'b0100;
  localparam logic [3:0] A_MOV = 4'b0101;

  state_t      state;
  logic [3:0]  flags_q;
  logic [15:0] cnt_q;
  logic        ill_q;
  logic        done_q;
  logic        dprst_q;

  logic [19:0] ic;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic        ibit;
  logic [3:0]  cmd;
  logic        sbit;
  logic        lnk;
  logic [3:0]  rd;

  assign ic   = bus.InstrControl;
  assign cond = ic[19:16];
  assign op   = ic[15:14];
  assign ibit = ic[13];
  assign cmd  = ic[12:9];
  assign sbit = ic[8];
  assign lnk  = ic[12];
  assign rd   = ic[3:0];

  logic       br;
  logic       m2r;
  logic       memw;
  logic [3:0] alu;
  logic       alusrc;
  logic [1:0] imm;
  logic       regw;
  logic [1:0] regsrc;
  logic       nop;
  logic       bad;
  logic       flagw;

  always_comb begin
    br     = 1'b0;
    m2r    = 1'b0;
    memw   = 1'b0;
    alu    = A_ADD;
    alusrc = 1'b0;
    imm    = 2'b00;
    regw   = 1'b0;
    regsrc = 2'b00;
    nop    = 1'b0;
    bad    = 1'b0;
    flagw  = 1'b0;
    unique case (op)
      2'b00: begin
        alusrc = ibit;
        regw   = 1'b1;
        flagw  = sbit;
        unique case (cmd)
          4'b0100: alu = A_ADD;
          4'b0010: alu = A_SUB;
          4'b0000: alu = A_AND;
          4'b1100: alu = A_ORR;
          4'b0001: alu = A_EOR;
          4'b1101: alu = A_MOV;
          4'b1010: begin
            alu   = A_SUB;
            regw  = 1'b0;
            flagw = 1'b1;
          end
          default: begin
            nop   = 1'b1;
            bad   = 1'b1;
            regw  = 1'b0;
            flagw = 1'b0;
          end
        endcase
      end
      2'b01: begin
        alusrc = 1'b1;
        imm    = 2'b01;
        if (sbit) begin
          m2r  = 1'b1;
          regw = 1'b1;
        end else begin
          memw   = 1'b1;
          regsrc = 2'b10;
        end
      end
      2'b10: begin
        if (lnk) begin
          nop = 1'b1;
          bad = 1'b1;
        end else begin
          alusrc = 1'b1;
          imm    = 2'b10;
          regsrc = 2'b01;
          br     = 1'b1;
        end
      end
      default: begin
        nop = 1'b1;
        bad = 1'b1;
      end
    endcase
  end

  logic n, z, c, v;
  logic condex;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex = 1'b0;
    unique case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  logic ok;
  logic run;
  logic act;
  logic pcsrc;
  logic halt;

  assign ok    = condex & ~nop;
  assign run   = (state == RUN);
  assign act   = (state != IDLE);
  assign pcsrc = ok & (br | (regw & (rd == 4'hF)));
  assign halt  = (op == 2'b10) & (cond == 4'hE)
               & ~lnk & (ic[11:0] == 12'hFFF);

  // Writes only commit in RUN; HALTED keeps decoding so "B ." holds PC.
  assign bus.Control = act ? {pcsrc, m2r, memw & ok & run, alu,
                              alusrc, imm, regw & ok & run, regsrc}
                           : 13'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      flags_q <= 4'd0;
      cnt_q   <= 16'd0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      dprst_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            dprst_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (bad) ill_q <= 1'b1;
          if (flagw & ok) flags_q <= bus.ALUFlags;
          if (halt) begin
            state  <= HALTED;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dp_rst      = dprst_q;
  assign bus.done        = done_q;
  assign bus.illegal     = ill_q;
  assign bus.flags       = flags_q;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Expected Control words are hand-encoded from the field layout.
module tb_control_unit;
  logic clk;
  logic rst;
  int   nrun;
  int   nfail;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [19:0] I_ADD  = 20'hE2801;
  localparam logic [19:0] I_CMP  = 20'hE3500;
  localparam logic [19:0] I_BEQ  = 20'h0A000;
  localparam logic [19:0] I_STR  = 20'h15801;
  localparam logic [19:0] I_HALT = 20'hEAFFF;
  localparam logic [19:0] I_BAD  = 20'hEF000;

  localparam logic [12:0] C_ADD  = 13'h0024;
  localparam logic [12:0] C_CMP  = 13'h0060;
  localparam logic [12:0] C_BT   = 13'h1031;
  localparam logic [12:0] C_BN   = 13'h0031;
  localparam logic [12:0] C_STR  = 13'h042A;
  localparam logic [12:0] C_STRN = 13'h002A;
  localparam logic [12:0] C_ADDH = 13'h0020;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.InstrControl = 20'd0;
    bus.ALUFlags = 4'd0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) cyc();
    nrun++;
    if (bus.dp_rst !== 1'b1) begin
      nfail++;
      $display("FAIL reset_dp_rst got %b want 1", bus.dp_rst);
    end
    nrun++;
    if (bus.Control !== 13'd0) begin
      nfail++;
      $display("FAIL reset_control got %h want 0", bus.Control);
    end
    nrun++;
    if (bus.instr_count !== 16'd0 || bus.flags !== 4'd0
        || bus.done !== 1'b0 || bus.illegal !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state cnt=%h flags=%b done=%b ill=%b want 0",
               bus.instr_count, bus.flags, bus.done, bus.illegal);
    end
  endtask

  task automatic test_add();
    do_start();
    nrun++;
    if (bus.dp_rst !== 1'b0) begin
      nfail++;
      $display("FAIL run_dp_rst got %b want 0", bus.dp_rst);
    end
    bus.InstrControl = I_ADD;
    bus.ALUFlags = 4'hF;
    #1;
    nrun++;
    if (bus.Control !== C_ADD) begin
      nfail++;
      $display("FAIL add_control got %h want %h", bus.Control, C_ADD);
    end
    cyc();
    nrun++;
    if (bus.instr_count !== 16'd1) begin
      nfail++;
      $display("FAIL add_count got %0d want 1", bus.instr_count);
    end
    nrun++;
    if (bus.flags !== 4'd0) begin
      nfail++;
      $display("FAIL add_noflags got %b want 0000", bus.flags);
    end
  endtask

  task automatic test_cmp_beq();
    bus.InstrControl = I_CMP;
    bus.ALUFlags = 4'b0100;
    #1;
    nrun++;
    if (bus.Control !== C_CMP) begin
      nfail++;
      $display("FAIL cmp_control got %h want %h", bus.Control, C_CMP);
    end
    cyc();
    nrun++;
    if (bus.flags !== 4'b0100) begin
      nfail++;
      $display("FAIL cmp_flags got %b want 0100", bus.flags);
    end
    bus.InstrControl = I_BEQ;
    bus.ALUFlags = 4'b0000;
    #1;
    nrun++;
    if (bus.Control !== C_BT) begin
      nfail++;
      $display("FAIL beq_taken got %h want %h", bus.Control, C_BT);
    end
    cyc();
    bus.InstrControl = I_CMP;
    bus.ALUFlags = 4'b0000;
    cyc();
    nrun++;
    if (bus.flags !== 4'b0000) begin
      nfail++;
      $display("FAIL cmp2_flags got %b want 0000", bus.flags);
    end
    bus.InstrControl = I_BEQ;
    #1;
    nrun++;
    if (bus.Control !== C_BN) begin
      nfail++;
      $display("FAIL beq_not got %h want %h", bus.Control, C_BN);
    end
    cyc();
    nrun++;
    if (bus.instr_count !== 16'd5) begin
      nfail++;
      $display("FAIL cmp_count got %0d want 5", bus.instr_count);
    end
  endtask

  task automatic test_str();
    bus.InstrControl = I_STR;
    #1;
    nrun++;
    if (bus.Control !== C_STR) begin
      nfail++;
      $display("FAIL str_ne_pass got %h want %h", bus.Control, C_STR);
    end
    cyc();
    bus.InstrControl = I_CMP;
    bus.ALUFlags = 4'b0100;
    cyc();
    bus.InstrControl = I_STR;
    bus.ALUFlags = 4'b0000;
    #1;
    nrun++;
    if (bus.Control !== C_STRN) begin
      nfail++;
      $display("FAIL str_ne_fail got %h want %h", bus.Control, C_STRN);
    end
    cyc();
    nrun++;
    if (bus.instr_count !== 16'd8) begin
      nfail++;
      $display("FAIL str_count got %0d want 8", bus.instr_count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    do_start();
    bus.InstrControl = I_ADD;
    repeat (3) cyc();
    bus.InstrControl = I_HALT;
    #1;
    nrun++;
    if (bus.done !== 1'b0) begin
      nfail++;
      $display("FAIL halt_early got %b want 0", bus.done);
    end
    cyc();
    nrun++;
    if (bus.done !== 1'b1 || bus.instr_count !== 16'd4) begin
      nfail++;
      $display("FAIL halt_enter done=%b cnt=%0d want 1,4",
               bus.done, bus.instr_count);
    end
    bus.start = 1'b1;
    repeat (3) cyc();
    bus.start = 1'b0;
    nrun++;
    if (bus.Control !== C_BT || bus.instr_count !== 16'd4
        || bus.done !== 1'b1 || bus.dp_rst !== 1'b0) begin
      nfail++;
      $display("FAIL halt_hold ctl=%h cnt=%0d done=%b dprst=%b",
               bus.Control, bus.instr_count, bus.done, bus.dp_rst);
    end
    bus.InstrControl = I_ADD;
    #1;
    nrun++;
    if (bus.Control !== C_ADDH) begin
      nfail++;
      $display("FAIL halt_nowrite got %h want %h", bus.Control, C_ADDH);
    end
    bus.InstrControl = I_BAD;
    cyc();
    nrun++;
    if (bus.illegal !== 1'b0) begin
      nfail++;
      $display("FAIL halt_noillegal got %b want 0", bus.illegal);
    end
  endtask

  task automatic test_illegal();
    logic [12:0] wr;
    do_reset();
    do_start();
    bus.InstrControl = I_BAD;
    #1;
    wr = bus.Control & 13'h1404;
    nrun++;
    if (wr !== 13'd0) begin
      nfail++;
      $display("FAIL bad_writes got %h want 0", wr);
    end
    cyc();
    nrun++;
    if (bus.illegal !== 1'b1) begin
      nfail++;
      $display("FAIL bad_set got %b want 1", bus.illegal);
    end
    bus.InstrControl = I_ADD;
    cyc();
    nrun++;
    if (bus.illegal !== 1'b1 || bus.instr_count !== 16'd2) begin
      nfail++;
      $display("FAIL bad_sticky ill=%b cnt=%0d want 1,2",
               bus.illegal, bus.instr_count);
    end
    bus.InstrControl = I_CMP;
    bus.ALUFlags = 4'hF;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nrun++;
    if (bus.flags !== 4'd0 || bus.instr_count !== 16'd0
        || bus.illegal !== 1'b0 || bus.dp_rst !== 1'b1
        || bus.Control !== 13'd0) begin
      nfail++;
      $display("FAIL mid_reset fl=%b cnt=%0d ill=%b dprst=%b ctl=%h",
               bus.flags, bus.instr_count, bus.illegal,
               bus.dp_rst, bus.Control);
    end
  endtask

  initial begin
    nrun = 0;
    nfail = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.InstrControl = 20'd0;
    bus.ALUFlags = 4'd0;
    test_reset();
    test_add();
    test_cmp_beq();
    test_str();
    test_halt();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- InstrControl  in  20  Instr[31:12]: [19:16] cond, [15:14] op, [13:8] funct (I=[13], cmd=[12:9], S=[8]), [7:4] Rn, [3:0] Rd; [11:0] also = Instr[23:12].
- ALUFlags  in  4  {N,Z,C,V} from datapath ALU, current cycle.
- Control  out  13  [12] PCSrc, [11] MemtoReg, [10] MemWrite, [9:6] ALUControl, [5] ALUSrc, [4:3] ImmSrc, [2] RegWrite, [1:0] RegSrc.
- dp_rst  out  1  holds datapath (PC, register file) in reset.
- done  out  1  program halted.
- illegal  out  1  sticky unsupported-instruction flag.
- flags  out  4  registered {N,Z,C,V}.
- instr_count  out  16  retired-instruction count.

Function
REQ-002 The FSM SHALL have states IDLE, RUN and HALTED: IDLE->RUN on start=1; RUN->HALTED on a halt instruction; HALTED persists until rst.
REQ-003 The outputs SHALL be: IDLE dp_rst=1, Control=0; RUN/HALTED dp_rst=0; done=1 only in HALTED.
REQ-004 The ALUControl encoding SHALL be 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (pass SrcB); any other cmd sets illegal and is a NOP.
REQ-005 For data-processing (op=00), decode SHALL be cmd 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR, 0001->EOR, 1101->MOV, 1010 (CMP)->SUB with RegWrite forced 0; ALUSrc=I; ImmSrc=00; RegSrc=00; RegWrite=1 otherwise.
REQ-006 For memory (op=01), decode SHALL be ALU ADD, ALUSrc=1, ImmSrc=01; LDR (funct[0]=1): MemtoReg=1, RegWrite=1, RegSrc=00; STR: MemWrite=1, RegWrite=0, RegSrc=10.
REQ-007 For branch (op=10), decode SHALL be ALU ADD, ALUSrc=1, ImmSrc=10, RegSrc=01, PCSrc=1, RegWrite=0; link (funct[4]=1) sets illegal and is a NOP.
REQ-008 op=11 SHALL set illegal and be a NOP.
REQ-009 PCSrc SHALL also be 1 when RegWrite=1 and Rd=1111.
REQ-010 CondEx SHALL be evaluated combinationally from cond and the registered flags per ARM codes 0000-1110; 1111 is never executed.
REQ-011 When CondEx=0 or the instruction is a NOP, PCSrc, MemWrite and RegWrite SHALL all be 0.
REQ-012 Flags SHALL load ALUFlags at the clock edge only in RUN, for op=00 with S=1 (CMP always) and CondEx=1.
REQ-013 The flags update SHALL be visible to the next instruction's CondEx, giving 1-cycle latency.
REQ-014 The halt instruction SHALL be op=10, cond=1110, funct[4]=0, InstrControl[11:0]=FFF ("B ."); it executes normally and the FSM enters HALTED at that edge.
REQ-015 In HALTED, decode SHALL continue; the self-branch holds PC while MemWrite and RegWrite are forced 0.
REQ-016 instr_count SHALL increment once per RUN cycle, including the halt instruction and condition-failed instructions.
REQ-017 instr_count SHALL saturate at FFFF and SHALL NOT count in IDLE or HALTED.
REQ-018 illegal SHALL set only in RUN and stay set until rst; execution continues.
REQ-019 start asserted outside IDLE SHALL be ignored.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL enter IDLE with flags=0, instr_count=0, illegal=0, done=0, dp_rst=1, Control=0.
REQ-021 Reset SHALL take priority over start and halt.
REQ-022 Reset mid-RUN SHALL abort with no further flag or count update at that edge.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset, no start for 10 cycles -> dp_rst=1, Control=0, instr_count=0.
- start, ADD R1,R0,#5 (E2801005) -> Control: ALUControl=0000, ALUSrc=1, RegWrite=1, PCSrc=0; instr_count=1 next cycle.
- CMP R0,#0 (E3500000) with ALUFlags=0100, then BEQ -> flags=0100 next cycle, BEQ gives PCSrc=1; same with ALUFlags=0000 -> PCSrc=0, RegWrite=0, MemWrite=0.
- STR (E5801000) under cond NE with Z=1 -> MemWrite=0; with Z=0 -> MemWrite=1, RegSrc=10, ImmSrc=01.
- EAFFFFFE after 3 instructions -> done=1 next cycle, instr_count=4 and frozen, PCSrc=1 held.
- Opcode F… (op=11) in RUN -> illegal=1 sticky, Control write bits 0; rst mid-RUN -> IDLE, all counters 0.
